sc_par_edge_acc: RTL and testbench

- Parallel stochastic-computing Roberts-cross edge detector over an M x N frame of pixel bitstreams.
- Adds a selectable combine mode, input-valid stalling, and start/busy/done sequencing.
- Accumulates each pixel's edge bitstream over an L-bit window into a binary count (SC-to-binary conversion).
- Sits between the bitstream generators (SNGs) and the downstream binary image writer.

---
 rtl/sc_par_edge_acc_if.sv | 43 ++++
 rtl/sc_par_edge_acc.sv | 142 ++++++++++++++
 tb/tb_sc_par_edge_acc.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/sc_par_edge_acc_if.sv
// ---------------------------------------------------------------------------
// sc_par_edge_acc_if
//   Bundles the control, bitstream and result signals of the parallel
//   stochastic Roberts-cross edge accumulator.
//
//   Signals:
//     start     - begin a conversion (honoured only while idle)
//     mode      - 0 = MUX scaled add, 1 = OR saturating add
//     sel       - random select bitstream used by the MUX add
//     in_valid  - in_bits carries a valid beat this cycle
//     in_bits   - one bit per pixel, row-major, index i*N+j
//     busy      - conversion in progress
//     done      - one-cycle pulse when out_count is final
//     out_count - per-pixel accumulated edge counts
//
//   Modports:
//     master - the bitstream source / result consumer
//     slave  - the accumulator itself
// ---------------------------------------------------------------------------
interface sc_par_edge_acc_if #(
    parameter int M  = 8,
    parameter int N  = 8,
    parameter int CW = 9
);
    logic            start;
    logic            mode;
    logic            sel;
    logic            in_valid;
    logic            in_bits   [0:M*N-1];
    logic            busy;
    logic            done;
    logic [CW-1:0]   out_count [0:M*N-1];

    modport master (
        output start, mode, sel, in_valid, in_bits,
        input  busy, done, out_count
    );

    modport slave (
        input  start, mode, sel, in_valid, in_bits,
        output busy, done, out_count
    );
endinterface

// File: rtl/sc_par_edge_acc.sv
// ---------------------------------------------------------------------------
// sc_par_edge_acc
//   Parallel stochastic-computing Roberts-cross edge detector over an M x N
//   frame of pixel bitstreams. Every accepted beat produces one edge bit per
//   interior pixel; those bits are summed over L beats into a binary count.
//
//   Ports:
//     clk   - rising-edge clock
//     reset - asynchronous, active-low reset
//     bus   - sc_par_edge_acc_if slave modport (start/mode/sel/in_valid/
//             in_bits in, busy/done/out_count out)
// ---------------------------------------------------------------------------
module sc_par_edge_acc #(
    parameter int M = 8,
    parameter int N = 8,
    parameter int L = 256
) (
    input  logic              clk,
    input  logic              reset,
    sc_par_edge_acc_if.slave  bus
);
    localparam int CW = $clog2(L + 1);
    localparam int P  = M * N;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   beat_cnt;
    logic            mode_q;
    logic            start_ok;
    logic            accept;
    logic            last_beat;
    logic            e_comb  [0:P-1];
    logic            e_q     [0:P-1];
    logic            v_q;
    logic [CW-1:0]   count_q [0:P-1];

    assign start_ok  = (state == IDLE) && bus.start;
    assign accept    = (state == RUN) && bus.in_valid;
    assign last_beat = accept && (beat_cnt == CW'(L - 1));

    // Next-state logic. DRAIN exists only to let the final beat pass
    // through the two-stage pipeline before done is raised.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = RUN;
            RUN:     if (last_beat) state_next = DRAIN;
            DRAIN:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Beat counter and mode latch; mode is frozen for the whole run so a
    // mid-run change on the input cannot corrupt the statistics.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            beat_cnt <= '0;
            mode_q   <= 1'b0;
        end else if (start_ok) begin
            beat_cnt <= '0;
            mode_q   <= bus.mode;
        end else if (accept) begin
            beat_cnt <= beat_cnt + CW'(1);
        end
    end

    // Roberts-cross edge bit per pixel. The two diagonal differences are
    // XORs of unipolar bitstreams; MUX mode halves their sum, OR mode
    // approximates a saturating add. Last row/column have no 2x2 window.
    for (genvar gi = 0; gi < M; gi++) begin : g_row
        for (genvar gj = 0; gj < N; gj++) begin : g_col
            if (gi < M - 1 && gj < N - 1) begin : g_int
                logic diag_a;
                logic diag_b;
                assign diag_a = bus.in_bits[gi*N + gj] ^ bus.in_bits[(gi+1)*N + gj + 1];
                assign diag_b = bus.in_bits[gi*N + gj + 1] ^ bus.in_bits[(gi+1)*N + gj];
                assign e_comb[gi*N + gj] = mode_q ? (diag_a | diag_b)
                                                  : (bus.sel ? diag_a : diag_b);
            end else begin : g_edge
                assign e_comb[gi*N + gj] = 1'b0;
            end
        end
    end

    // Stage 1: register edge bits alongside the beat-accepted flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v_q <= 1'b0;
            for (int k = 0; k < P; k++) begin
                e_q[k] <= 1'b0;
            end
        end else begin
            v_q <= accept;
            for (int k = 0; k < P; k++) begin
                e_q[k] <= e_comb[k];
            end
        end
    end

    // Stage 2: SC-to-binary accumulation. Clearing on start cannot collide
    // with an add because v_q is never set while the FSM sits in IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < P; k++) begin
                count_q[k] <= '0;
            end
        end else if (start_ok) begin
            for (int k = 0; k < P; k++) begin
                count_q[k] <= '0;
            end
        end else if (v_q) begin
            for (int k = 0; k < P; k++) begin
                count_q[k] <= count_q[k] + CW'(e_q[k]);
            end
        end
    end

    assign bus.busy = (state == RUN) || (state == DRAIN);
    assign bus.done = (state == DONE);

    always_comb begin
        for (int k = 0; k < P; k++) begin
            bus.out_count[k] = count_q[k];
        end
    end
endmodule

// File: tb/tb_sc_par_edge_acc.sv
// ---------------------------------------------------------------------------
// tb_sc_par_edge_acc
//   Testbench for sc_par_edge_acc with M=4, N=4, L=16. Each run pushes its
//   expected counts, done cycle and busy length into a queue; a monitor
//   pops and compares whenever done is presented.
// ---------------------------------------------------------------------------
module tb_sc_par_edge_acc;
    localparam int M  = 4;
    localparam int N  = 4;
    localparam int L  = 16;
    localparam int CW = $clog2(L + 1);
    localparam int P  = M * N;

    typedef struct packed {
        logic [P-1:0][7:0] counts;
        int                done_cyc;
        int                busy_len;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    sc_par_edge_acc_if #(.M(M), .N(N), .CW(CW)) bus ();

    sc_par_edge_acc #(.M(M), .N(N), .L(L)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    exp_t         exp_q [$];
    exp_t         mon_e;
    int           checks   = 0;
    int           errors   = 0;
    int           cyc      = 0;
    int           busy_run = 0;
    logic [P-1:0] beat_bits [L];
    logic         beat_sel  [L];

    // Free-running cycle index, advanced on every active edge.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Reference edge bit for pixel k, computed straight from the 2x2 window.
    function automatic logic edge_bit(input logic [P-1:0] b, input logic s,
                                      input logic m, input int k);
        int   i;
        int   j;
        logic da;
        logic db;
        i = k / N;
        j = k % N;
        if (i == M - 1 || j == N - 1) return 1'b0;
        da = b[k] ^ b[k + N + 1];
        db = b[k + 1] ^ b[k + N];
        return m ? (da | db) : (s ? da : db);
    endfunction

    task automatic drive_beat(input logic [P-1:0] b, input logic s, input logic v);
        for (int k = 0; k < P; k++) bus.in_bits[k] = b[k];
        bus.sel      = s;
        bus.in_valid = v;
    endtask

    // One conversion: stall inserts an idle cycle before every beat, poke
    // pulses start in RUN and DRAIN, abort_at >= 0 resets after that many beats.
    task automatic applyStimulus(input logic m, input bit stall, input bit poke,
                                 input int abort_at);
        exp_t e;
        int   s_cyc;
        int   cnt;
        int   run_len;
        for (int k = 0; k < P; k++) begin
            cnt = 0;
            for (int t = 0; t < L; t++) cnt += int'(edge_bit(beat_bits[t], beat_sel[t], m, k));
            e.counts[k] = 8'(cnt);
        end
        drive_beat('0, 1'b0, 1'b0);
        bus.start = 1'b1;
        bus.mode  = m;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.mode  = ~m;
        s_cyc     = cyc;
        run_len   = stall ? 2 * L : L;
        e.done_cyc = s_cyc + run_len + 1;
        e.busy_len = run_len + 1;
        if (abort_at < 0) exp_q.push_back(e);
        for (int t = 0; t < L; t++) begin
            if (stall) begin
                drive_beat(P'($urandom()), 1'($urandom()), 1'b0);
                @(posedge clk); #1;
                if (t > 0) begin
                    cnt = 0;
                    for (int u = 0; u < t; u++) cnt += int'(edge_bit(beat_bits[u], beat_sel[u], m, 0));
                    checkOutput($sformatf("stall_hold[%0d]", t), int'(bus.out_count[0]), cnt);
                end
            end
            if (abort_at == t) begin
                reset = 1'b0;
                #1;
                checkOutput("abort_busy", int'(bus.busy), 0);
                checkOutput("abort_done", int'(bus.done), 0);
                for (int k = 0; k < P; k++)
                    checkOutput($sformatf("abort_count[%0d]", k), int'(bus.out_count[k]), 0);
                drive_beat('0, 1'b0, 1'b0);
                @(posedge clk); #1;
                reset = 1'b1;
                return;
            end
            drive_beat(beat_bits[t], beat_sel[t], 1'b1);
            bus.start = poke && (t == 5);
            @(posedge clk); #1;
            bus.start = 1'b0;
        end
        drive_beat('0, 1'b0, 1'b0);
        bus.start = poke;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic load_directed(input logic [P-1:0] b);
        for (int t = 0; t < L; t++) begin
            beat_bits[t] = b;
            beat_sel[t]  = (t % 2 == 0);
        end
    endtask

    task automatic load_random();
        for (int t = 0; t < L; t++) begin
            beat_bits[t] = P'($urandom()) | 16'hF888;
            beat_sel[t]  = 1'($urandom());
        end
    endtask

    // Scoreboard monitor: samples on the falling edge, away from updates.
    always @(negedge clk) begin
        if (!reset) begin
            busy_run = 0;
        end else begin
            if (bus.busy) busy_run++;
            if (bus.done) begin
                if (exp_q.size() == 0) begin
                    checkOutput("spurious_done", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    checkOutput("done_cycle", cyc, mon_e.done_cyc);
                    checkOutput("busy_len", busy_run, mon_e.busy_len);
                    for (int k = 0; k < P; k++)
                        checkOutput($sformatf("count[%0d]", k), int'(bus.out_count[k]),
                                    int'(mon_e.counts[k]));
                end
                busy_run = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: got 1 expected 0");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        reset        = 1'b0;
        bus.start    = 1'b0;
        bus.mode     = 1'b0;
        drive_beat('0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_busy", int'(bus.busy), 0);
        checkOutput("reset_done", int'(bus.done), 0);
        for (int k = 0; k < P; k++)
            checkOutput($sformatf("reset_count[%0d]", k), int'(bus.out_count[k]), 0);
        reset = 1'b1;
        @(posedge clk); #1;

        // All ones: both diagonals cancel, every count is 0.
        load_directed(16'hFFFF);
        applyStimulus(1'b0, 1'b0, 1'b0, -1);
        // Single lit pixel (0,0): MUX gives 8, OR gives 16.
        load_directed(16'h0001);
        applyStimulus(1'b0, 1'b0, 1'b0, -1);
        applyStimulus(1'b1, 1'b0, 1'b0, -1);
        // Stall between every beat.
        applyStimulus(1'b0, 1'b1, 1'b0, -1);
        // Abort after 5 beats, then a full clean run.
        applyStimulus(1'b0, 1'b0, 1'b0, 5);
        applyStimulus(1'b0, 1'b0, 1'b0, -1);
        // start pulses during RUN and DRAIN must be ignored.
        applyStimulus(1'b0, 1'b0, 1'b1, -1);
        // Random interior, last row and column forced high.
        load_random();
        applyStimulus(1'b0, 1'b0, 1'b0, -1);
        load_random();
        applyStimulus(1'b1, 1'b0, 1'b0, -1);

        repeat (5) @(posedge clk);
        #1;
        checkOutput("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
